uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600: serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 4: receive FIFO entries, power of two, 2..16.
REQ-004 SHALL have port clk  input  1: single clock for all logic.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port rx  input  1: asynchronous serial line, idle high, 8 data bits, LSB first.
REQ-007 SHALL have port rd_en  input  1: pops the FIFO head when valid=1.
REQ-008 SHALL have port data_out  output  8: FIFO head in show-ahead mode, meaningful only while valid=1.
REQ-009 SHALL have port valid  output  1: FIFO non-empty.
REQ-010 SHALL have port received  output  1: one-clk pulse for each byte written into the FIFO.
REQ-011 SHALL have port frame_err  output  1: one-clk pulse when a stop bit samples 0.
REQ-012 SHALL have port overflow  output  1: sticky flag, set when a byte is dropped because the FIFO is full.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer, with both flops reset to 1, before any other use.
REQ-014 SHALL generate a 16x-oversample tick every DIV=CLK_HZ/(BAUD*16) clks (integer division) from a free-running counter that wraps at DIV-1.
REQ-015 SHALL implement the states IDLE, START, DATA, STOP and BREAK, plus PARITY when the macro in REQ-026 is defined.
REQ-016 In IDLE, a synchronized rx=0 on a tick SHALL move the FSM to START and clear the tick count.
REQ-017 START SHALL sample on its 8th tick (mid-bit): rx=1 returns the FSM to IDLE with no output (glitch rejection); rx=0 moves it to DATA.
REQ-018 DATA SHALL sample every 16 ticks after the start-bit midpoint, shift the samples LSB-first into an 8-bit register, and move to STOP after bit 7.
REQ-019 STOP SHALL sample 16 ticks after the last data sample: rx=1 writes the byte to the FIFO and returns to IDLE; rx=0 pulses frame_err, discards the byte, and moves to BREAK.
REQ-020 BREAK SHALL hold until synchronized rx=1, then move to IDLE.
REQ-021 received and the resulting valid/data_out update SHALL appear on the clk after the stop-bit sample clk.
REQ-022 On a FIFO write while full with no pop in the same clk, the FIFO SHALL drop the new byte and set overflow; stored entries SHALL stay unchanged and received SHALL not pulse.
REQ-023 When a write and a pop occur in the same clk while full, the pop SHALL complete first and the write SHALL then be accepted, with no overflow.
REQ-024 rd_en while valid=0 SHALL be ignored; a pop SHALL clear overflow; read and write pointers SHALL wrap modulo DEPTH, with a count width of log2(DEPTH)+1.

Reset
REQ-025 While rst_n=0, the FSM SHALL be in IDLE, the tick counter, shift register, FIFO pointers and count SHALL be 0, and valid, received, frame_err and overflow SHALL be 0.
REQ-025a While rst_n=0, data_out SHALL be 8'h00.
REQ-025b A reset asserted mid-frame SHALL abort the frame and empty the FIFO.

Configuration
REQ-026 With UART_RX_PARITY_EN defined, the block SHALL add a PARITY state between DATA and STOP that samples a ninth bit 16 ticks after bit 7 and checks it against even parity.
REQ-027 With UART_RX_PARITY_EN defined, the block SHALL add output parity_err (1 bit), which pulses for one clk when the parity check fails; the failing byte SHALL be discarded, and the stop-bit check SHALL still run.
REQ-028 Without UART_RX_PARITY_EN, the block SHALL have no PARITY state and no parity_err port, and the frame SHALL be 10 bits.

Verification (CLK_HZ=1600000, BAUD=10000, so DIV=10 and bit period = 160 clks; DEPTH=4)
REQ-029 Scenario: send frame 0x55 -> received pulses once, valid=1, data_out=0x55; rd_en for 1 clk -> valid=0.
REQ-030 Scenario: drive rx low for 40 clks, then high -> no received and no frame_err pulse, and the FSM returns to IDLE.
REQ-031 Scenario: send 0xA3 with stop bit 0 and hold rx low for 500 clks, then release and send 0x3C -> one frame_err pulse, then exactly one byte is stored, 0x3C.
REQ-032 Scenario: send 0x01..0x05 back-to-back with no reads -> overflow=1 after the 5th frame; four pops read 0x01..0x04, and overflow clears on the first pop.
REQ-033 Scenario: fill the FIFO with 4 bytes, then assert rd_en on the same clk that the 5th byte (0x77) is written -> overflow stays 0, and the pops read 0x02, 0x03, 0x04, 0x77.
REQ-034 Scenario: assert rst_n=0 during bit 4 of a frame while valid=1 -> all outputs go to 0 and, after rst_n returns to 1, the next full frame 0x9E is received correctly; with UART_RX_PARITY_EN defined, 0x9E sent with parity bit 0 -> parity_err pulses and valid stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver (8 data bits, LSB first, one stop bit, 16x oversampling)
//   feeding a small show-ahead receive FIFO.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     Undefined (default): 10-bit frame  start | d0..d7 | stop
//     Defined            : 11-bit frame  start | d0..d7 | even parity | stop,
//                          plus the parity_err output.
//
// Parameters
//   CLK_HZ : system clock frequency in Hz
//   BAUD   : serial bit rate
//   DEPTH  : FIFO entries, power of two, 2..16
//
// Ports
//   clk        in   single clock for all logic
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   rd_en      in   pop FIFO head (ignored while valid=0)
//   data_out   out  FIFO head (show-ahead), 8'h00 while empty
//   valid      out  FIFO non-empty
//   received   out  one-clk pulse per byte accepted into the FIFO
//   frame_err  out  one-clk pulse when the stop bit samples 0
//   overflow   out  sticky: a byte was dropped on a full FIFO; cleared by pop
//   parity_err out  (UART_RX_PARITY_EN only) one-clk pulse on parity failure
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       received,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overflow
);

    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_BREAK  = 3'd4
    } state_e;

    // -----------------------------------------------------------------------
    // Input synchronizer: both flops reset to the idle level so reset release
    // never looks like a start bit.
    // -----------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Free-running 16x oversample tick generator.
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + DIV_W'(1);
    end

    // -----------------------------------------------------------------------
    // Receive FSM. tcnt_q counts oversample ticks inside a bit; the start bit
    // is sampled 8 ticks after detection (mid-bit), every later bit 16 ticks
    // after the previous sample. wr_stb_q is a registered write request, so
    // the FIFO (and received) update on the clk after the stop-bit sample.
    // -----------------------------------------------------------------------
    state_e     state_q;
    logic [3:0] tcnt_q;
    logic [2:0] bitcnt_q;
    logic [7:0] shreg_q;
    logic       wr_stb_q;
    logic       frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic       par_bad_q;
    logic       parity_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tcnt_q       <= '0;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            wr_stb_q     <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (tick && !rx_sync_q) begin
                        state_q <= S_START;
                        tcnt_q  <= '0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (tcnt_q == 4'd7) begin
                            // Line back high at mid-bit: treat as a glitch.
                            tcnt_q   <= '0;
                            bitcnt_q <= '0;
                            state_q  <= rx_sync_q ? S_IDLE : S_DATA;
                        end else begin
                            tcnt_q <= tcnt_q + 4'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + 4'd1;   // 15 -> 0 on the sample tick
                        if (tcnt_q == 4'd15) begin
                            shreg_q  <= {rx_sync_q, shreg_q[7:1]};
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            // Even parity: the parity bit equals XOR of data.
                            par_bad_q    <= (rx_sync_q != ^shreg_q);
                            parity_err_q <= (rx_sync_q != ^shreg_q);
                            state_q      <= S_STOP;
                        end
                    end
                end
`endif

                S_STOP: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
                                wr_stb_q <= !par_bad_q;
`else
                                wr_stb_q <= 1'b1;
`endif
                                state_q  <= S_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end
                        end
                    end
                end

                // Wait out a held-low line so it is not taken as new starts.
                S_BREAK: begin
                    if (rx_sync_q) state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Receive FIFO. A pop on a full FIFO frees the head slot in the same clk,
    // so a simultaneous write lands where the popped head was.
    // -----------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic          received_q;
    logic          pop, push, drop, full;

    assign full = (cnt_q == CW'(DEPTH));
    assign pop  = rd_en && (cnt_q != '0);
    assign push = wr_stb_q && (!full || pop);
    assign drop = wr_stb_q && full && !pop;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (pop)       overflow_d = 1'b0;
        else if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            received_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            received_q <= push;
        end
    end

    // Storage needs no reset: data_out is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= shreg_q;
    end

    assign valid     = (cnt_q != '0);
    assign data_out  = valid ? mem_q[rptr_q] : 8'h00;
    assign received  = received_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
